quad_decoder: RTL and testbench

//   Registered, parametrised quadrature rotary-encoder decoder. Successor to the combinational

---
 rtl/quad_decoder.sv | 179 +++++++++++++++++
 tb/tb_quad_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop sync, per-channel debounce, clocked Gray-code FSM,
// x1/x4 step generation, wrap/saturate position counter and sticky illegal-transition flag.
module quad_decoder #(
    parameter int CNT_WIDTH = 8,
    parameter int DEBOUNCE  = 4,
    parameter bit X4_MODE   = 1'b1,
    parameter bit WRAP      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_x,
    input  logic                 enc_y,
    input  logic                 clear,
    input  logic                 err_clear,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 dir,
    output logic                 step_pulse,
    output logic                 err
);

    typedef enum logic [2:0] {ST_INIT, ST_S00, ST_S10, ST_S11, ST_S01} state_t;

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int INIT_W = $clog2(DEBOUNCE + 2);

    logic [1:0]            w_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_filt;
    logic [1:0][DB_W-1:0]  r_db_ctr;
    state_t                r_state;
    logic [INIT_W-1:0]     r_init_cnt;
    logic signed [3:0]     r_sub;

    logic [1:0]            w_move;
    logic                  w_active;
    logic                  w_illegal;
    logic                  w_step;
    logic                  w_step_up;
    logic signed [3:0]     w_sub_sum;
    logic signed [3:0]     w_sub_nxt;

    function automatic state_t xy_to_state(input logic [1:0] xy);
        case (xy)
            2'b00:   return ST_S00;
            2'b10:   return ST_S10;
            2'b11:   return ST_S11;
            default: return ST_S01;
        endcase
    endfunction

    // Position along the CW cycle 00->10->11->01, so a move is a 2-bit difference.
    function automatic logic [1:0] xy_pos(input logic [1:0] xy);
        case (xy)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] state_pos(input state_t s);
        case (s)
            ST_S10:  return 2'd1;
            ST_S11:  return 2'd2;
            ST_S01:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] next_count(input logic [CNT_WIDTH-1:0] c,
                                                        input logic up);
        if (up) begin
            if (!WRAP && (c == {CNT_WIDTH{1'b1}})) return c;
            return c + CNT_WIDTH'(1);
        end
        if (!WRAP && (c == '0)) return c;
        return c - CNT_WIDTH'(1);
    endfunction

    assign w_raw = {enc_x, enc_y};

    // Stage 1: synchronisers and debounce filters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_filt   <= '0;
            r_db_ctr <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_state == ST_INIT) begin
                    r_filt[i]   <= r_sync2[i];
                    r_db_ctr[i] <= '0;
                end else if (r_sync2[i] != r_filt[i]) begin
                    if (r_db_ctr[i] == DB_W'(DEBOUNCE - 1)) begin
                        r_filt[i]   <= r_sync2[i];
                        r_db_ctr[i] <= '0;
                    end else begin
                        r_db_ctr[i] <= r_db_ctr[i] + DB_W'(1);
                    end
                end else begin
                    r_db_ctr[i] <= '0;
                end
            end
        end
    end

    assign w_active  = (r_state != ST_INIT);
    assign w_move    = xy_pos(r_filt) - state_pos(r_state);
    assign w_illegal = w_active && (w_move == 2'd2);

    // Stage 2: edge classification and x1 detent accumulation
    always_comb begin
        w_step    = 1'b0;
        w_step_up = 1'b0;
        w_sub_sum = r_sub;
        w_sub_nxt = r_sub;
        if (w_active && (w_move == 2'd1 || w_move == 2'd3)) begin
            if (X4_MODE) begin
                w_step    = 1'b1;
                w_step_up = (w_move == 2'd1);
                w_sub_nxt = '0;
            end else begin
                w_sub_sum = r_sub + ((w_move == 2'd1) ? 4'sd1 : -4'sd1);
                if (w_sub_sum == 4'sd4 || w_sub_sum == -4'sd4) begin
                    // A full detent only completes on arrival at 00; elsewhere hold at +/-3.
                    if (r_filt == 2'b00) begin
                        w_step    = 1'b1;
                        w_step_up = (w_sub_sum == 4'sd4);
                        w_sub_nxt = '0;
                    end else begin
                        w_sub_nxt = (w_sub_sum == 4'sd4) ? 4'sd3 : -4'sd3;
                    end
                end else begin
                    w_sub_nxt = w_sub_sum;
                end
            end
        end
    end

    // Stage 3: FSM, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_sub      <= '0;
            count      <= '0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_pulse <= w_step;
            if (w_step) dir <= w_step_up;
            if (clear)       count <= '0;
            else if (w_step) count <= next_count(count, w_step_up);
            err <= w_illegal | (err & ~err_clear);

            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == INIT_W'(DEBOUNCE + 1)) r_state <= xy_to_state(r_filt);
                    else r_init_cnt <= r_init_cnt + INIT_W'(1);
                end
                default: begin
                    if (w_illegal) begin
                        r_state <= xy_to_state(r_filt);
                        r_sub   <= '0;
                    end else if (w_move != 2'd0) begin
                        r_state <= xy_to_state(r_filt);
                        r_sub   <= w_sub_nxt;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: three instances (x4/wrap, x1/wrap, x4/saturate) share one encoder
// stream; a phase-level Gray-code model predicts counts, directions, pulses and err.
module tb_quad_decoder;

    localparam int DB = 4;

    logic clk;
    logic reset;
    logic enc_x;
    logic enc_y;
    logic clear;
    logic err_clear;
    logic [2:0][7:0] o_cnt;
    logic [2:0]      o_dir;
    logic [2:0]      o_pulse;
    logic [2:0]      o_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_pulse [3] = '{0, 0, 0};
    int p0      [3] = '{0, 0, 0};

    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    bit   m_wrap    [3] = '{1'b1, 1'b1, 1'b0};
    int   m_cnt     [3];
    int   m_dir     [3];
    int   m_pulse   [3];
    int   m_idx;
    int   m_sub;
    int   m_err;

    quad_decoder #(.CNT_WIDTH(8), .DEBOUNCE(DB), .X4_MODE(1'b1), .WRAP(1'b1)) u_x4w (
        .clk(clk), .reset(reset), .enc_x(enc_x), .enc_y(enc_y), .clear(clear),
        .err_clear(err_clear), .count(o_cnt[0]), .dir(o_dir[0]), .step_pulse(o_pulse[0]),
        .err(o_err[0]));

    quad_decoder #(.CNT_WIDTH(8), .DEBOUNCE(DB), .X4_MODE(1'b0), .WRAP(1'b1)) u_x1w (
        .clk(clk), .reset(reset), .enc_x(enc_x), .enc_y(enc_y), .clear(clear),
        .err_clear(err_clear), .count(o_cnt[1]), .dir(o_dir[1]), .step_pulse(o_pulse[1]),
        .err(o_err[1]));

    quad_decoder #(.CNT_WIDTH(8), .DEBOUNCE(DB), .X4_MODE(1'b1), .WRAP(1'b0)) u_x4s (
        .clk(clk), .reset(reset), .enc_x(enc_x), .enc_y(enc_y), .clear(clear),
        .err_clear(err_clear), .count(o_cnt[2]), .dir(o_dir[2]), .step_pulse(o_pulse[2]),
        .err(o_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (o_pulse[k]) n_pulse[k] <= n_pulse[k] + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic [1:0] xy);
        enc_x = xy[1];
        enc_y = xy[0];
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int pos_of(input logic [1:0] xy);
        for (int i = 0; i < 4; i++)
            if (seq[i] == xy) return i;
        return 0;
    endfunction

    task automatic model_reset(input int idx);
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_dir[k] = 0;
        end
        m_err = 0;
        m_sub = 0;
        m_idx = idx;
    endtask

    task automatic bump(input int k, input int s);
        int c;
        c = m_cnt[k] + s;
        if (m_wrap[k]) c = (c + 256) % 256;
        else if (c < 0) c = 0;
        else if (c > 255) c = 255;
        m_cnt[k] = c;
        m_dir[k] = (s > 0) ? 1 : 0;
        m_pulse[k]++;
    endtask

    task automatic model_move(input logic [1:0] xy);
        int d;
        int s;
        d = ((pos_of(xy) - m_idx) % 4 + 4) % 4;
        if (d == 2) begin
            m_err = 1;
            m_sub = 0;
        end else if (d != 0) begin
            s = (d == 1) ? 1 : -1;
            bump(0, s);
            bump(2, s);
            m_sub += s;
            if (m_sub == 4 || m_sub == -4) begin
                bump(1, (m_sub > 0) ? 1 : -1);
                m_sub = 0;
            end
        end
        m_idx = pos_of(xy);
    endtask

    task automatic begin_phase();
        for (int k = 0; k < 3; k++) begin
            p0[k]      = n_pulse[k];
            m_pulse[k] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s/cnt%0d", tag, k), int'(o_cnt[k]), m_cnt[k]);
            chk($sformatf("%s/dir%0d", tag, k), int'(o_dir[k]), m_dir[k]);
            chk($sformatf("%s/pulses%0d", tag, k), n_pulse[k] - p0[k], m_pulse[k]);
            chk($sformatf("%s/err%0d", tag, k), int'(o_err[k]), m_err);
        end
    endtask

    task automatic phase(input logic [1:0] xy, input int hold, input string tag);
        begin_phase();
        drive(xy);
        tick(hold);
        model_move(xy);
        check_all(tag);
    endtask

    initial begin
        int nidx;
        int g;
        reset = 1'b1; enc_x = 1'b0; enc_y = 1'b0; clear = 1'b0; err_clear = 1'b0;
        model_reset(0);
        tick(3);
        begin_phase();
        check_all("reset");
        reset = 1'b0;
        tick(12);
        check_all("init00");

        // Full CW detent with latency check on the first edge
        begin_phase();
        drive(2'b10);
        tick(6);
        chk("lat_early", int'(o_cnt[0]), 0);
        tick(1);
        chk("lat_cnt", int'(o_cnt[0]), 1);
        chk("lat_pulse", int'(o_pulse[0]), 1);
        tick(1);
        chk("pulse_width", int'(o_pulse[0]), 0);
        tick(2);
        model_move(2'b10);
        check_all("cw1");
        phase(2'b11, 10, "cw2");
        phase(2'b01, 10, "cw3");
        phase(2'b00, 10, "cw4");

        // Half step forward and back
        phase(2'b10, 10, "half_fwd");
        phase(2'b00, 10, "half_back");

        // Glitches: 3 cycles rejected, 4 cycles accepted (then released)
        begin_phase();
        enc_x = 1'b1; tick(3); enc_x = 1'b0; tick(12);
        check_all("glitch3");
        begin_phase();
        enc_x = 1'b1; tick(4); enc_x = 1'b0; tick(16);
        model_move(2'b10);
        model_move(2'b00);
        check_all("glitch4");

        // Illegal jumps; err_clear coinciding with a new illegal jump
        phase(2'b11, 10, "jump00_11");
        begin_phase();
        drive(2'b00);
        tick(6);
        err_clear = 1'b1; tick(1); err_clear = 1'b0;
        chk("err_hold", int'(o_err[0]), 1);
        tick(3);
        model_move(2'b00);
        check_all("jump11_00");
        begin_phase();
        err_clear = 1'b1; tick(1); err_clear = 1'b0; tick(1);
        m_err = 0;
        check_all("err_clear");

        // Clear, then CCW from zero: wrap vs saturate
        begin_phase();
        clear = 1'b1; tick(1); clear = 1'b0; tick(1);
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        check_all("clear");
        phase(2'b01, 10, "ccw_from0");
        phase(2'b11, 10, "ccw2");
        phase(2'b10, 10, "ccw3");
        phase(2'b00, 10, "ccw_detent");

        // Clear on the same edge as a step
        begin_phase();
        drive(2'b10);
        tick(6);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("clr_step_cnt", int'(o_cnt[0]), 0);
        chk("clr_step_pulse", int'(o_pulse[0]), 1);
        chk("clr_step_dir", int'(o_dir[0]), 1);
        tick(3);
        model_move(2'b10);
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        check_all("clear_step");

        // Random legal walk with occasional short glitches
        for (int i = 0; i < 40; i++) begin
            begin_phase();
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(1, DB - 1);
                enc_x = ~enc_x; tick(g); enc_x = ~enc_x; tick(2);
            end
            case ($urandom_range(0, 4))
                0:       nidx = m_idx;
                1, 2:    nidx = (m_idx + 1) % 4;
                default: nidx = (m_idx + 3) % 4;
            endcase
            drive(seq[nidx]);
            tick($urandom_range(8, 14));
            model_move(seq[nidx]);
            check_all($sformatf("rand%0d", i));
        end

        // Encoder parked at 11 through reset
        reset = 1'b1;
        drive(2'b11);
        tick(3);
        model_reset(2);
        begin_phase();
        check_all("park_reset");
        reset = 1'b0;
        tick(12);
        check_all("park_init");
        phase(2'b01, 10, "park_cw");
        phase(2'b10, 10, "park_jump");

        // Reset lands on the edge where a step would have registered
        drive(2'b11);
        tick(6);
        reset = 1'b1;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_mid/cnt%0d", k), int'(o_cnt[k]), 0);
            chk($sformatf("rst_mid/dir%0d", k), int'(o_dir[k]), 0);
            chk($sformatf("rst_mid/pulse%0d", k), int'(o_pulse[k]), 0);
            chk($sformatf("rst_mid/err%0d", k), int'(o_err[k]), 0);
        end
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
